// File: rtl/tt_input_conditioner.sv
// Board-side input stage: synchronises and debounces the dedicated inputs and the
// reset button, and sequences a minimum-length, synchronously released design reset.
module tt_input_conditioner #(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 50000,
  parameter logic [7:0]  DEBOUNCE_MASK     = 8'hFF,
  parameter int unsigned RESET_HOLD_CYCLES = 1024,
  parameter bit          BTN_ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_raw,
  input  logic       btn_raw,
  output logic [7:0] ui_in,
  output logic       rst_n,
  output logic       btn_pressed
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic              BTN_IDLE  = BTN_ACTIVE_LOW;

  typedef enum logic {HOLD, RUN} state_t;

  logic [SYNC_STAGES-1:0][7:0] ui_sync_q;
  logic [SYNC_STAGES-1:0]      btn_sync_q;
  logic [7:0]                  ui_s;
  logic                        btn_s_p;

  // Synchroniser chains; the button chain idles at its not-pressed level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ui_sync_q  <= '0;
      btn_sync_q <= {SYNC_STAGES{BTN_IDLE}};
    end else begin
      ui_sync_q  <= {ui_sync_q[SYNC_STAGES-2:0], ui_raw};
      btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign ui_s    = ui_sync_q[SYNC_STAGES-1];
  assign btn_s_p = btn_sync_q[SYNC_STAGES-1] ^ BTN_IDLE;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    if (DEBOUNCE_MASK[i]) begin : g_db
      logic [DB_W-1:0] cnt_q, cnt_d;
      logic            out_q, out_d;

      always_comb begin
        cnt_d = '0;
        out_d = out_q;
        if (ui_s[i] != out_q) begin
          if (cnt_q == DB_LAST) out_d = ui_s[i];
          else                  cnt_d = cnt_q + DB_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
          out_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          out_q <= out_d;
        end
      end

      assign ui_in[i] = out_q;
    end else begin : g_sync
      assign ui_in[i] = ui_s[i];
    end
  end

  // Button debounce runs on the polarity-corrected level, so the output flop is btn_pressed.
  logic [DB_W-1:0] btn_cnt_q, btn_cnt_d;
  logic            btn_db_q, btn_db_d;

  always_comb begin
    btn_cnt_d = '0;
    btn_db_d  = btn_db_q;
    if (btn_s_p != btn_db_q) begin
      if (btn_cnt_q == DB_LAST) btn_db_d  = btn_s_p;
      else                      btn_cnt_d = btn_cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_cnt_q <= '0;
      btn_db_q  <= 1'b0;
    end else begin
      btn_cnt_q <= btn_cnt_d;
      btn_db_q  <= btn_db_d;
    end
  end

  assign btn_pressed = btn_db_q;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              rst_n_q, rst_n_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      rst_n_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rst_n_q    <= rst_n_d;
    end
  end

  // Reset sequencer: hold counts only while the debounced button is released.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rst_n_d    = rst_n_q;
    case (state_q)
      HOLD: begin
        rst_n_d = 1'b0;
        if (btn_db_q) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          hold_cnt_d = '0;
          rst_n_d    = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      RUN: begin
        rst_n_d = 1'b1;
        if (btn_db_q) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          rst_n_d    = 1'b0;
        end
      end
      default: begin
        state_d    = HOLD;
        hold_cnt_d = '0;
        rst_n_d    = 1'b0;
      end
    endcase
  end

  assign rst_n = rst_n_q;

endmodule

// File: tb/tb_tt_input_conditioner.sv
// Scoreboard bench for tt_input_conditioner: expectations are queued against absolute
// edge numbers when stimulus is driven and compared on the following falling edges.
`timescale 1ns/1ps
module tb_tt_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ui_raw = 8'h00;
  logic       btn_raw = 1'b1;
  logic [7:0] ui_in;
  logic       rst_n;
  logic       btn_pressed;

  tt_input_conditioner #(
    .SYNC_STAGES      (2),
    .DEBOUNCE_CYCLES  (4),
    .DEBOUNCE_MASK    (8'h0F),
    .RESET_HOLD_CYCLES(8),
    .BTN_ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ui_raw     (ui_raw),
    .btn_raw    (btn_raw),
    .ui_in      (ui_in),
    .rst_n      (rst_n),
    .btn_pressed(btn_pressed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int SEL_UI = 0, SEL_RSTN = 1, SEL_BTN = 2;

  typedef struct {
    int         at;
    int         sel;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      SEL_UI:   return ui_in;
      SEL_RSTN: return {7'b0, rst_n};
      default:  return {7'b0, btn_pressed};
    endcase
  endfunction

  // rel = edge number counted from the first edge after the current falling edge.
  function automatic void expect_at(input int rel, input int sel, input logic [7:0] val,
                                    input string tag);
    exp_t e;
    int   idx;
    e.at  = cyc + rel;
    e.sel = sel;
    e.val = val;
    e.tag = $sformatf("%s@e%0d", tag, rel);
    idx   = sb.size();
    for (int k = 0; k < sb.size(); k++) begin
      if (sb[k].at > e.at) begin
        idx = k;
        break;
      end
    end
    sb.insert(idx, e);
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      check(mon_e.tag, observe(mon_e.sel), mon_e.val);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Board reset asserted before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_ui_in", ui_in, 8'h00);
    check("rst_rst_n", {7'b0, rst_n}, 8'h00);
    check("rst_btn", {7'b0, btn_pressed}, 8'h00);
    step(2);

    // Release with bit 0 held high: hold sequence and debounce accept together.
    rst    = 1'b0;
    ui_raw = 8'h01;
    expect_at(1, SEL_UI, 8'h00, "acc_ui");
    expect_at(5, SEL_UI, 8'h00, "acc_ui");
    expect_at(6, SEL_UI, 8'h01, "acc_ui");
    expect_at(1, SEL_RSTN, 8'h00, "hold_rstn");
    expect_at(7, SEL_RSTN, 8'h00, "hold_rstn");
    expect_at(8, SEL_RSTN, 8'h01, "hold_rstn");
    step(10);

    // Bit 1 high for 3 cycles: rejected.
    for (int k = 1; k <= 10; k++) expect_at(k, SEL_UI, 8'h01, "rej_ui");
    ui_raw = 8'h03;
    step(3);
    ui_raw = 8'h01;
    step(7);

    // Bit 1 high for exactly 4 cycles: accepted, then released 4 edges after it drops.
    expect_at(5, SEL_UI, 8'h01, "acc4_ui");
    expect_at(6, SEL_UI, 8'h03, "acc4_ui");
    expect_at(9, SEL_UI, 8'h03, "acc4_ui");
    expect_at(10, SEL_UI, 8'h01, "acc4_ui");
    ui_raw = 8'h03;
    step(4);
    ui_raw = 8'h01;
    step(8);

    // One-cycle pulse on unmasked bit 5.
    expect_at(1, SEL_UI, 8'h01, "pulse_ui");
    expect_at(2, SEL_UI, 8'h21, "pulse_ui");
    expect_at(3, SEL_UI, 8'h01, "pulse_ui");
    ui_raw = 8'h21;
    step(1);
    ui_raw = 8'h01;
    step(4);

    // 20-cycle button press while running.
    expect_at(5, SEL_BTN, 8'h00, "press_btn");
    expect_at(5, SEL_RSTN, 8'h01, "press_rstn");
    expect_at(6, SEL_BTN, 8'h01, "press_btn");
    expect_at(7, SEL_RSTN, 8'h00, "press_rstn");
    expect_at(25, SEL_BTN, 8'h01, "release_btn");
    expect_at(26, SEL_BTN, 8'h00, "release_btn");
    expect_at(33, SEL_RSTN, 8'h00, "release_rstn");
    expect_at(34, SEL_RSTN, 8'h01, "release_rstn");
    btn_raw = 1'b0;
    step(20);
    btn_raw = 1'b1;
    step(16);

    // 3-cycle button glitch never resets the design.
    for (int k = 4; k <= 10; k++) begin
      expect_at(k, SEL_BTN, 8'h00, "glitch_btn");
      expect_at(k, SEL_RSTN, 8'h01, "glitch_rstn");
    end
    btn_raw = 1'b0;
    step(3);
    btn_raw = 1'b1;
    step(9);

    // Fresh reset, then a second reset at hold count 5 / bit-2 debounce count 2.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    ui_raw = 8'h05;
    step(4);
    rst = 1'b1;
    #1;
    check("mid_ui_in", ui_in, 8'h00);
    check("mid_rst_n", {7'b0, rst_n}, 8'h00);
    check("mid_btn", {7'b0, btn_pressed}, 8'h00);
    step(1);
    rst = 1'b0;
    expect_at(5, SEL_UI, 8'h00, "mid_rel_ui");
    expect_at(6, SEL_UI, 8'h05, "mid_rel_ui");
    expect_at(7, SEL_RSTN, 8'h00, "mid_rel_rstn");
    expect_at(8, SEL_RSTN, 8'h01, "mid_rel_rstn");
    step(10);

    check("sb_drain", 8'(sb.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
